// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM with conditional-execution gating of architectural writes
module mc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Cond,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;
  state_t state, state_nx;
  logic [3:0] flags;
  logic cond_ex, rd_pc;
  logic [1:0] alu_dec;
  assign rd_pc = (Rd == 4'hf);
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign alu_dec = (Funct[4:1] == 4'b0100) ? 2'b00 :
                   (Funct[4:1] == 4'b0010) ? 2'b01 :
                   (Funct[4:1] == 4'b0000) ? 2'b10 :
                   (Funct[4:1] == 4'b1100) ? 2'b11 : 2'b00;
  // condition check against the stored {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = !flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = !flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = !flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = !flags[0];
      4'b1000: cond_ex = flags[1] && !flags[2];
      4'b1001: cond_ex = !flags[1] || flags[2];
      4'b1010: cond_ex = flags[3] == flags[0];
      4'b1011: cond_ex = flags[3] != flags[0];
      4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // state register and flag capture from flag-setting data-processing ops
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      state <= state_nx;
      if ((state == EXECR || state == EXECI) && Funct[0] && cond_ex) flags <= ALUFlags;
    end
  end
  // next-state and per-state control outputs; failed conditions only mask writes
  always_comb begin
    state_nx   = state;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_nx  = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_nx  = (Op == 2'b01) ? MEMADR :
                    (Op == 2'b10) ? BRANCH :
                    (Op == 2'b11) ? FETCH  :
                    Funct[5] ? EXECI : EXECR;
      end
      MEMADR: begin
        ALUSrcB  = 2'b01;
        state_nx = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc   = 1'b1;
        state_nx = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex && !rd_pc;
        PCWrite   = cond_ex && rd_pc;
        state_nx  = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
        state_nx = FETCH;
      end
      EXECR: begin
        ALUControl = alu_dec;
        state_nx   = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_nx   = ALUWB;
      end
      ALUWB: begin
        RegWrite = cond_ex && !rd_pc;
        PCWrite  = cond_ex && rd_pc;
        state_nx = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
        state_nx  = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: scoreboard bench for the multicycle sequencer
module tb_mc_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] cond = 4'he, rd = 4'h0, alu_flags = 4'h0;
  logic pc_write, mem_write, reg_write, ir_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src, alu_control;
  logic [16:0] got;
  typedef struct {logic [16:0] v; string nm;} exp_t;
  exp_t scb[$];
  int n_chk = 0, n_fail = 0;
  string tag = "";
  mc_sequencer dut (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Cond(cond), .Rd(rd),
    .ALUFlags(alu_flags), .PCWrite(pc_write), .MemWrite(mem_write),
    .RegWrite(reg_write), .IRWrite(ir_write), .AdrSrc(adr_src),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ResultSrc(result_src),
    .ImmSrc(imm_src), .RegSrc(reg_src), .ALUControl(alu_control)
  );
  always #5 clk = ~clk;
  assign got = {pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
                alu_src_b, result_src, imm_src, reg_src, alu_control};
  // monitor: one expected control vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t e;
      e = scb.pop_front();
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (pc,mw,rw,ir,adr,sa,sb,rs,imm,rsrc,alu)", e.nm, got, e.v);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
  task automatic ex(input string nm, input bit pc, mw, rw, ir, adr,
                    input logic [1:0] sa, sb, rs, alu);
    exp_t e;
    e.v  = {pc, mw, rw, ir, adr, sa, sb, rs, op, op == 2'b01, op == 2'b10, alu};
    e.nm = {tag, "/", nm};
    scb.push_back(e);
  endtask
  task automatic go(input string t, input logic [1:0] o, input logic [5:0] f,
                    input logic [3:0] c, input logic [3:0] r, input logic [3:0] af);
    tag = t; op = o; funct = f; cond = c; rd = r; alu_flags = af;
    ex("fetch",  1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 2'd0);
    ex("decode", 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd2, 2'd0);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic dp(input string t, input logic [5:0] f, input logic [3:0] c,
                    input logic [3:0] r, input logic [3:0] af, input logic [1:0] alu,
                    input bit pc, input bit rw);
    go(t, 2'b00, f, c, r, af);
    if (f[5]) ex("execi", 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, alu);
    else      ex("execr", 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, alu);
    ex("aluwb", pc, 0, rw, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc(4);
  endtask
  task automatic br(input string t, input logic [3:0] c, input bit pc);
    go(t, 2'b10, 6'b0, c, 4'h0, 4'h0);
    ex("branch", pc, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0);
    cyc(3);
  endtask
  task automatic str(input string t, input logic [3:0] c, input bit mw);
    go(t, 2'b01, 6'b011000, c, 4'h2, 4'h0);
    ex("memadr",   0, 0,  0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0);
    ex("memwrite", 0, mw, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc(4);
  endtask
  task automatic ldr(input string t, input logic [3:0] c, input logic [3:0] r,
                     input bit pc, input bit rw);
    go(t, 2'b01, 6'b011001, c, r, 4'h0);
    ex("memadr",  0,  0, 0,  0, 0, 2'd0, 2'd1, 2'd0, 2'd0);
    ex("memread", 0,  0, 0,  0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
    ex("memwb",   pc, 0, rw, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0);
    cyc(5);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    dp("add_imm", 6'b101000, 4'he, 4'h2, 4'h0, 2'b00, 0, 1);
    br("beq_flags_clear", 4'b0000, 0);
    dp("subs_reg", 6'b000101, 4'he, 4'h3, 4'b0100, 2'b01, 0, 1);
    br("beq_taken", 4'b0000, 1);
    br("bne_not_taken", 4'b0001, 0);
    str("str_ne_fail", 4'b0001, 0);
    str("str_al", 4'he, 1);
    ldr("ldr_pc", 4'he, 4'hf, 1, 0);
    ldr("ldr_r4", 4'he, 4'h4, 0, 1);
    dp("orr_reg", 6'b011000, 4'he, 4'h5, 4'h0, 2'b11, 0, 1);
    dp("and_imm", 6'b100000, 4'he, 4'h6, 4'h0, 2'b10, 0, 1);
    dp("mov_reg", 6'b011010, 4'he, 4'h7, 4'h0, 2'b00, 0, 1);
    go("op11", 2'b11, 6'b0, 4'he, 4'h1, 4'h0);
    cyc(2);
    dp("adds_ne_fail", 6'b001001, 4'b0001, 4'h8, 4'b0000, 2'b00, 0, 0);
    br("beq_flags_held", 4'b0000, 1);
    dp("add_pc", 6'b001000, 4'he, 4'hf, 4'h0, 2'b00, 1, 0);
    dp("subs_neg", 6'b000101, 4'he, 4'h9, 4'b1000, 2'b01, 0, 1);
    br("blt_taken", 4'b1011, 1);
    br("bge_not_taken", 4'b1010, 0);
    br("bmi_taken", 4'b0100, 1);
    go("ldr_rst", 2'b01, 6'b011001, 4'he, 4'h3, 4'h0);
    ex("memadr",  0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0);
    ex("memread", 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    br("bmi_after_rst", 4'b0100, 0);
    n_chk++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", scb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
